// File: rtl/serpent_sbox_pkg.sv
// Shared Serpent S-box tables (inverse for the datapath, forward for stimulus) and engine FSM state type.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package serpent_sbox_pkg;

    localparam int NIBBLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // INV_SBOX[i][v] is the preimage of v under forward Serpent S-box i.
    localparam logic [3:0] INV_SBOX [8][16] = '{
        '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
        '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
        '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
        '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
        '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
        '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
        '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
        '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
    };

    // Standard forward Serpent S-boxes S0..S7, used to build round-trip stimulus.
    localparam logic [3:0] FWD_SBOX [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

endpackage

// File: rtl/serpent_inv_sbox_nibble.sv
// One 4-bit inverse Serpent S-box lane, table selected by a 3-bit index.
// Latency: purely combinational.
// Backpressure: none, no state.
module serpent_inv_sbox_nibble
    import serpent_sbox_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic [2:0] i_index,
    output logic [3:0] o_nibble
);

    assign o_nibble = INV_SBOX[i_index][i_nibble];

endmodule

// File: rtl/serpent_inv_sbox_engine.sv
// Inverse Serpent S-box layer over a 128-bit block, NIBBLES_PER_CYCLE lanes per cycle (SERPENT_INV_SBOX_PARALLEL_EN: all 32 at once).
// Latency: result valid 32/P edges after accept (1 edge with SERPENT_INV_SBOX_PARALLEL_EN); one block in flight.
// Backpressure: result held in DONE until i_ready; o_ready only while IDLE.
module serpent_inv_sbox_engine
    import serpent_sbox_pkg::*;
#(
    parameter int NIBBLES_PER_CYCLE = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    input  logic [2:0]   i_Sbox_index,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data
);

`ifdef SERPENT_INV_SBOX_PARALLEL_EN
    localparam int LANES = NIBBLES;
`else
    localparam int LANES  = NIBBLES_PER_CYCLE;
    localparam int CHUNKS = NIBBLES / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
`endif
    localparam int LW = 4 * LANES;

    state_e         state_q, state_d;
    logic [127:0]   data_q, data_d;
    logic [2:0]     idx_q, idx_d;
    logic [LW-1:0]  lane_in;
    logic [LW-1:0]  lane_out;
`ifndef SERPENT_INV_SBOX_PARALLEL_EN
    logic [CW-1:0]  cnt_q, cnt_d;
`endif

    // Feed the lanes from the working register: the current chunk, or the whole block when fully parallel.
`ifdef SERPENT_INV_SBOX_PARALLEL_EN
    assign lane_in = data_q;
`else
    assign lane_in = data_q[int'(cnt_q) * LW +: LW];
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serpent_inv_sbox_nibble u_nib (
            .i_nibble (lane_in[4*g +: 4]),
            .i_index  (idx_q),
            .o_nibble (lane_out[4*g +: 4])
        );
    end

    // Next-state: capture in IDLE, substitute in place in BUSY, hold result in DONE until taken.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
`ifndef SERPENT_INV_SBOX_PARALLEL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_BUSY;
                    data_d  = i_data;
                    idx_d   = i_Sbox_index;
`ifndef SERPENT_INV_SBOX_PARALLEL_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef SERPENT_INV_SBOX_PARALLEL_EN
                data_d  = lane_out;
                state_d = ST_DONE;
`else
                data_d[int'(cnt_q) * LW +: LW] = lane_out;
                // Counter parks on the last chunk rather than wrapping.
                if (cnt_q == LAST_CHUNK) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working register, captured index and chunk counter; reset abandons any block in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
`ifndef SERPENT_INV_SBOX_PARALLEL_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
`ifndef SERPENT_INV_SBOX_PARALLEL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_data  = data_q;

endmodule

// File: tb/tb_serpent_inv_sbox_engine.sv
// Self-checking bench for serpent_inv_sbox_engine: countdown reference model plus directed and random round trips.
// Latency: expects result 32/P edges after accept (1 with SERPENT_INV_SBOX_PARALLEL_EN).
// Backpressure: exercises held results under i_ready low and ignored offers while not IDLE.
module tb_serpent_inv_sbox_engine;
    import serpent_sbox_pkg::*;

    localparam int P = 8;
`ifdef SERPENT_INV_SBOX_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 32 / P;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [127:0] i_data  = '0;
    logic [2:0]   i_idx   = '0;
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_data;

    always #5 clk = ~clk;

    serpent_inv_sbox_engine #(.NIBBLES_PER_CYCLE(P)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_Sbox_index (i_idx),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Inverse found by searching the forward table, independent of the inverse tables.
    function automatic logic [3:0] inv_nib(input logic [2:0] ix, input logic [3:0] v);
        for (int j = 0; j < 16; j++) begin
            if (FWD_SBOX[ix][j] == v) return 4'(j);
        end
        return 4'h0;
    endfunction

    function automatic logic [127:0] inv_blk(input logic [127:0] x, input logic [2:0] ix);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[4*k +: 4] = inv_nib(ix, x[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [127:0] fwd_blk(input logic [127:0] x, input logic [2:0] ix);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[4*k +: 4] = FWD_SBOX[ix][x[4*k +: 4]];
        return r;
    endfunction

    // Reference model: accept when ready, count LAT edges down, then present result until taken.
    logic         m_ready  = 1'b1;
    logic         m_valid  = 1'b0;
    logic [127:0] m_data   = '0;
    logic [127:0] m_result = '0;
    int           m_left   = 0;
    bit           chk_en   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (m_ready) begin
            if (i_valid) begin
                m_ready  <= 1'b0;
                m_result <= inv_blk(i_data, i_idx);
                m_left   <= LAT;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_data  <= m_result;
            end
        end else if (m_valid && i_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    // Compare DUT handshake and result against the model every cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("mdl_o_ready", {127'b0, o_ready}, {127'b0, m_ready});
            check("mdl_o_valid", {127'b0, o_valid}, {127'b0, m_valid});
            if (m_valid) check("mdl_o_data", o_data, m_data);
        end
    end

    // Offer a block from a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [127:0] d, input logic [2:0] ix);
        int t;
        i_valid = 1'b1;
        i_data  = d;
        i_idx   = ix;
        t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL offer_timeout got=o_ready_low exp=o_ready_high");
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        i_idx   = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!o_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_valid) begin
            checks++;
            failures++;
            $display("FAIL result_timeout got=o_valid_low exp=o_valid_high");
        end
    endtask

    initial begin
        logic [127:0] d, x, exp_d;
        logic [2:0]   ix;
        int           k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_ready", {127'b0, o_ready}, 128'd1);
        check("rst_o_valid", {127'b0, o_valid}, 128'd0);
        check("rst_o_data",  o_data, 128'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // All-zero block, index 0: latency and literal result
        i_ready = 1'b1;
        offer(128'd0, 3'd0);
        wait_result(k);
        check("lat_zero", 128'(k), 128'(LAT));
        check("zero_idx0", o_data, 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD);
        @(negedge clk);

        // All-ones block, index 0
        offer({128{1'b1}}, 3'd0);
        wait_result(k);
        check("lat_ones", 128'(k), 128'(LAT));
        check("ones_idx0", o_data, 128'h2222_2222_2222_2222_2222_2222_2222_2222);
        @(negedge clk);

        // Held result under backpressure; offers during DONE ignored
        i_ready = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        offer(d, 3'd2);
        wait_result(k);
        exp_d = inv_blk(d, 3'd2);
        for (int n = 0; n < 10; n++) begin
            i_valid = 1'b1;
            i_data  = ~d;
            i_idx   = 3'd7;
            @(negedge clk);
            check("hold_o_data",  o_data, exp_d);
            check("hold_o_valid", {127'b0, o_valid}, 128'd1);
            check("hold_o_ready", {127'b0, o_ready}, 128'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("release_o_valid", {127'b0, o_valid}, 128'd0);
        check("release_o_ready", {127'b0, o_ready}, 128'd1);

        // Reset during BUSY abandons the block
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        offer(d, 3'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_valid", {127'b0, o_valid}, 128'd0);
        check("midrst_o_ready", {127'b0, o_ready}, 128'd1);
        check("midrst_o_data",  o_data, 128'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("postrst_o_ready", {127'b0, o_ready}, 128'd1);
        check("postrst_o_valid", {127'b0, o_valid}, 128'd0);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        offer(d, 3'd6);
        wait_result(k);
        check("postrst_lat",  128'(k), 128'(LAT));
        check("postrst_data", o_data, inv_blk(d, 3'd6));
        @(negedge clk);

        // Index changes during BUSY must not affect the block
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        offer(d, 3'd3);
        i_idx = 3'd5;
        wait_result(k);
        check("idx_captured", o_data, inv_blk(d, 3'd3));
        @(negedge clk);

        // Random round trips across all indices with random backpressure
        i_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            x  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ix = 3'(n % 8);
            offer(fwd_blk(x, ix), ix);
            wait_result(k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand_roundtrip", o_data, x);
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
